// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: machine widths, PC increment and
// the {pc, instr} record buffered between fetch and decode.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch front-end bundle: ROM request bus, execute redirect and decode
// output port. master = fetch unit, slave = its environment.
interface instr_fetch_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] ibus_addr;
    logic [ILEN-1:0] ibus_data;
    logic            ibus_valid;
    logic            ibus_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;

    modport master (
        output ibus_addr, ibus_valid, out_valid, out_pc, out_instr,
        input  ibus_data, ibus_ready, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  ibus_addr, ibus_valid, out_valid, out_pc, out_instr,
        output ibus_data, ibus_ready, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush.
// Head reads as zero while empty so downstream never sees stale data.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    fetch_entry_t  mem [DEPTH];
    logic          do_push, do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Flush overrides both sides; a push is never taken while full.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: PC register, one-word-per-cycle ROM requests,
// {pc, instr} buffering toward decode, and redirect-driven flush/restart.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    instr_fetch_if.master  bus
);
    logic [XLEN-1:0] pc;
    logic            started;
    logic            full, empty, fire;
    fetch_entry_t    push_entry, head;

    // Request only from registered state and redirect; never from ibus_ready.
    assign bus.ibus_valid = started && !full && !bus.redirect_valid;
    assign bus.ibus_addr  = {pc[XLEN-1:2], 2'b00};
    assign fire           = bus.ibus_valid && bus.ibus_ready;

    assign push_entry.pc    = {pc[XLEN-1:2], 2'b00};
    assign push_entry.instr = bus.ibus_data;

    assign bus.out_valid = !empty;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (bus.redirect_valid)
                pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            else if (fire)
                pc <= pc + PC_STEP;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fire),
        .pop     (bus.out_valid && bus.out_ready),
        .flush   (bus.redirect_valid),
        .din     (push_entry),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table for streaming,
// back-pressure, stalls and redirects, plus wrap and async-reset sequences.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    instr_fetch_if b1 ();
    instr_fetch_if b2 ();

    // ROM model: word i holds 32'h1000_0000 + i
    assign b1.ibus_data = 32'h1000_0000 + {2'b00, b1.ibus_addr[31:2]};
    assign b2.ibus_data = 32'h1000_0000 + {2'b00, b2.ibus_addr[31:2]};

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.master));
    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset_n(reset_n), .bus(b2.master));

    typedef struct {
        logic        rst;
        logic        ir;
        logic        ordy;
        logic        rv;
        logic [31:0] rpc;
        logic        iv;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] opc;
        logic [31:0] oins;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(logic rst, logic ir, logic ordy, logic rv, logic [31:0] rpc,
                              logic iv, logic [31:0] addr, logic ov, logic [31:0] opc,
                              logic [31:0] oins);
        vec_t r;
        r.rst = rst; r.ir = ir; r.ordy = ordy; r.rv = rv; r.rpc = rpc;
        r.iv = iv; r.addr = addr; r.ov = ov; r.opc = opc; r.oins = oins;
        vecs.push_back(r);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        b1.ibus_ready = 1'b1; b1.out_ready = 1'b1;
        b1.redirect_valid = 1'b0; b1.redirect_pc = '0;
        b2.ibus_ready = 1'b1; b2.out_ready = 1'b1;
        b2.redirect_valid = 1'b0; b2.redirect_pc = '0;

        //  rst ir or rv rpc             iv addr            ov pc              instr
        v(0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        // streaming, one per cycle
        v(1, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        v(1, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0);
        v(1, 1, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h1000_0000);
        v(1, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h4,          32'h1000_0001);
        v(1, 1, 1, 0, 32'h0,          1, 32'hC,          1, 32'h8,          32'h1000_0002);
        v(1, 1, 1, 0, 32'h0,          1, 32'h10,         1, 32'hC,          32'h1000_0003);
        v(0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        // back-pressure until full, then one pop
        v(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        v(1, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0);
        v(1, 1, 0, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h1000_0000);
        v(1, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0,          32'h1000_0000);
        v(1, 1, 0, 0, 32'h0,          1, 32'hC,          1, 32'h0,          32'h1000_0000);
        v(1, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'h0,          32'h1000_0000);
        v(1, 1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h0,          32'h1000_0000);
        v(1, 1, 0, 0, 32'h0,          1, 32'h10,         1, 32'h4,          32'h1000_0001);
        v(1, 1, 0, 0, 32'h0,          0, 32'h14,         1, 32'h4,          32'h1000_0001);
        v(0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        // ibus_ready stall 1,0,0,1
        v(1, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        v(1, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0);
        v(1, 0, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h1000_0000);
        v(1, 0, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0);
        v(1, 1, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0);
        v(1, 0, 1, 0, 32'h0,          1, 32'h8,          1, 32'h4,          32'h1000_0001);
        v(1, 0, 1, 0, 32'h0,          1, 32'h8,          0, 32'h0,          32'h0);
        v(0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        // redirect with 3 queued
        v(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
        v(1, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0);
        v(1, 1, 0, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h1000_0000);
        v(1, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0,          32'h1000_0000);
        v(1, 1, 0, 1, 32'h0000_0103,  0, 32'hC,          1, 32'h0,          32'h1000_0000);
        v(1, 1, 1, 0, 32'h0,          1, 32'h100,        0, 32'h0,          32'h0);
        v(1, 1, 1, 0, 32'h0,          1, 32'h104,        1, 32'h100,        32'h1000_0040);
        v(1, 1, 1, 0, 32'h0,          1, 32'h108,        1, 32'h104,        32'h1000_0041);
        // redirect + pop + ibus_ready in the same cycle
        v(1, 1, 1, 1, 32'h0000_0200,  0, 32'h10C,        1, 32'h108,        32'h1000_0042);
        v(1, 0, 1, 0, 32'h0,          1, 32'h200,        0, 32'h0,          32'h0);
        v(1, 1, 1, 0, 32'h0,          1, 32'h200,        0, 32'h0,          32'h0);
        v(1, 1, 1, 0, 32'h0,          1, 32'h204,        1, 32'h200,        32'h1000_0080);
        // back-to-back redirects, last wins
        v(1, 1, 0, 1, 32'h0000_0300,  0, 32'h208,        1, 32'h204,        32'h1000_0081);
        v(1, 1, 0, 1, 32'h0000_0404,  0, 32'h300,        0, 32'h0,          32'h0);
        v(1, 1, 0, 0, 32'h0,          1, 32'h404,        0, 32'h0,          32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n           = vecs[i].rst;
            b1.ibus_ready     = vecs[i].ir;
            b1.out_ready      = vecs[i].ordy;
            b1.redirect_valid = vecs[i].rv;
            b1.redirect_pc    = vecs[i].rpc;
            #1;
            chk($sformatf("row%0d ibus_valid", i), {31'b0, b1.ibus_valid}, {31'b0, vecs[i].iv});
            chk($sformatf("row%0d ibus_addr", i),  b1.ibus_addr, vecs[i].addr);
            chk($sformatf("row%0d out_valid", i),  {31'b0, b1.out_valid}, {31'b0, vecs[i].ov});
            chk($sformatf("row%0d out_pc", i),     b1.out_pc, vecs[i].opc);
            chk($sformatf("row%0d out_instr", i),  b1.out_instr, vecs[i].oins);
        end

        // PC wrap from RESET_PC = FFFFFFF8, then async reset mid-stream
        @(negedge clk);
        reset_n = 1'b0;
        b1.ibus_ready = 1'b1; b1.out_ready = 1'b1; b1.redirect_valid = 1'b0;
        #1;
        chk("wrap reset addr", b2.ibus_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("wrap c1 valid", {31'b0, b2.ibus_valid}, 32'd1);
        chk("wrap c1 addr", b2.ibus_addr, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("wrap c2 pc", b2.out_pc, 32'hFFFF_FFF8);
        chk("wrap c2 instr", b2.out_instr, 32'h4FFF_FFFE);
        chk("wrap c2 addr", b2.ibus_addr, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap c3 pc", b2.out_pc, 32'hFFFF_FFFC);
        chk("wrap c3 instr", b2.out_instr, 32'h4FFF_FFFF);
        chk("wrap c3 addr", b2.ibus_addr, 32'h0);
        @(negedge clk); #1;
        chk("wrap c4 pc", b2.out_pc, 32'h0);
        chk("wrap c4 instr", b2.out_instr, 32'h1000_0000);
        chk("pre-reset u1 valid", {31'b0, b1.out_valid}, 32'd1);
        chk("pre-reset u1 pc", b1.out_pc, 32'h8);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async rst u1 out_valid", {31'b0, b1.out_valid}, 32'd0);
        chk("async rst u1 ibus_valid", {31'b0, b1.ibus_valid}, 32'd0);
        chk("async rst u2 out_valid", {31'b0, b2.out_valid}, 32'd0);
        chk("async rst u2 ibus_valid", {31'b0, b2.ibus_valid}, 32'd0);
        chk("async rst u2 out_pc", b2.out_pc, 32'h0);
        chk("async rst u2 addr", b2.ibus_addr, 32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch front-end that sits directly upstream of the instruction ROM and drives its ibus port. It keeps the program counter, issues one word fetch per cycle, and buffers returned instructions with their PCs in a small FIFO. Decode consumes the FIFO through a valid/ready port. A redirect from execute (taken branch or jump) flushes the FIFO and restarts fetch.

Parameters:
RESET_PC, 32'h00000000, address fetched first after reset.
FIFO_DEPTH, 4, number of {pc, instr} entries buffered; must be a power of two, at least 2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous active-low reset.
ibus_addr  out  32  byte address of the current fetch; always word-aligned.
ibus_data  in  32  instruction word; valid in the same cycle as ibus_valid && ibus_ready.
ibus_valid  out  1  fetch request.
ibus_ready  in  1  slave accepts the request and presents data this cycle.
redirect_valid  in  1  flush and restart fetch this cycle.
redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
out_valid  out  1  FIFO head holds an instruction.
out_ready  in  1  decode accepts the head this cycle.
out_pc  out  32  PC of the head instruction.
out_instr  out  32  head instruction word.

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, FIFO empty, started=0. Outputs: ibus_valid=0, out_valid=0, out_pc=0, out_instr=0, ibus_addr=RESET_PC.
- started is set on the first clock edge after reset release. This delays the first request by one cycle.
- ibus_addr = {pc[31:2], 2'b00}.
- ibus_valid = started && !full && !redirect_valid. This is combinational from registered state and redirect_valid only; there is no path from ibus_ready to ibus_valid.
- Fetch transfer: when ibus_valid && ibus_ready, push {pc, ibus_data} into the FIFO and set pc <= pc + 4.
  - The add is modulo 2^32, so 32'hFFFFFFFC wraps to 0.
  - ibus_data is sampled only in that cycle.
- ibus_ready=0: no push and pc holds. The request stays asserted with the same address until accepted.
- Throughput: one instruction per cycle when ibus_ready=1, the FIFO is not full, and decode pops every cycle.
- Full: ibus_valid=0. A push is never allowed while full, even if a pop happens in the same cycle. Fetch resumes the cycle after count drops below FIFO_DEPTH.
- Output: out_valid = (count != 0). out_pc and out_instr come from the head entry and read 0 when empty.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid=1), at the clock edge:
  - FIFO cleared (count=0, pointers reset), pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle, because ibus_valid is forced 0.
  - A pop in the same cycle is ignored; redirect wins.
  - out_valid is 0 in the following cycle.
  - The first fetch at the new pc issues in the next cycle.
- Back-to-back redirects: the last one wins. No fetch is issued while redirect_valid is held high.
- Reset mid-operation: all state returns immediately to reset values, regardless of ibus or out handshakes in flight.
- Count width: $clog2(FIFO_DEPTH)+1 bits. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32.
  - ILEN=32.
  - PC_STEP=4.
  - Type fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, head.
  - Asynchronous active-low reset.
- instr_fetch holds the pc register, the started flag and the request logic.

Test Plan:
1. Reset release, ibus_ready=1, out_ready=1, ROM word i = 32'h1000_0000+i:
   - ibus_valid rises 1 cycle after release.
   - out_pc sequence 0,4,8,... with out_instr 32'h10000000, 32'h10000001, ...
   - One instruction per cycle.
2. out_ready=0, ibus_ready=1:
   - After 4 pushes (pc 0..C), ibus_valid=0 and ibus_addr holds 32'h10.
   - Raising out_ready pops pc 0 first, and fetch of 32'h10 resumes the next cycle.
3. ibus_ready toggles 1,0,0,1:
   - ibus_addr holds 32'h4 through the stall.
   - FIFO receives exactly pc 0 then pc 4, with no duplicates.
4. Redirect with 3 entries queued, redirect_pc=32'h0000_0103:
   - Next cycle out_valid=0 and ibus_addr=32'h100.
   - First out_pc afterwards is 32'h100; stale entries are never output.
5. Redirect, pop and push all in the same cycle:
   - FIFO ends empty.
   - pc=redirect target.
   - The popped entry is not reissued.
6. Wrap and reset:
   - RESET_PC=32'hFFFFFFF8 gives out_pc FFFFFFF8, FFFFFFFC, 00000000.
   - Asserting reset_n=0 mid-stream clears out_valid and ibus_valid immediately, without waiting for a clock.
